// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer
// Power-up and recovery sequencer for the board clock infrastructure, clocked
// from the free-running EPB clock. Order of events: hold the MMCM in reset,
// qualify LOCKED, pulse the IDELAYCTRL reset, wait for RDY, then release the
// design-wide power-on reset. Lock loss, RDY loss or a software request
// re-runs only the part of the sequence that is needed.
//
// Optional build macro: CLK_RST_SEQ_LOCK_FILTER_EN
//   defined   - in RUN, lock loss needs 4 consecutive low cycles of the
//               synchronized LOCKED; shorter dropouts are ignored.
//   undefined - in RUN, a single low cycle of synchronized LOCKED is a loss.
// Outside RUN, every state reacts to a single low cycle regardless.

module clk_rst_sequencer #(
  parameter int MMCM_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int IDELAY_RST_CYCLES   = 8,
  parameter int RDY_TIMEOUT_CYCLES  = 4096
) (
  input  logic       epb_clk,
  input  logic       rst,
  input  logic       mmcm_locked,
  input  logic       idelay_rdy,
  input  logic       force_rst,
  output logic       mmcm_rst,
  output logic       idelay_rst,
  output logic       op_power_on_rst,
  output logic       sys_rdy,
  output logic [7:0] relock_count,
  output logic       timeout_err
);

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The single shared counter is sized for the longest interval.
  localparam int MAX_CYCLES = max_int(max_int(max_int(MMCM_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                              max_int(LOCK_STABLE_CYCLES, IDELAY_RST_CYCLES)),
                                      RDY_TIMEOUT_CYCLES);
  localparam int CNT_W = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] MMCM_LAST   = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_TO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLY_LAST   = CNT_W'(IDELAY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RDY_TO_LAST = CNT_W'(RDY_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    S_MMCM_RST    = 3'd0,
    S_WAIT_LOCK   = 3'd1,
    S_LOCK_STABLE = 3'd2,
    S_IDLY_RST    = 3'd3,
    S_WAIT_RDY    = 3'd4,
    S_RUN         = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_lock_sync;
  logic [1:0]       r_rdy_sync;
  logic             r_mmcm_rst;
  logic             r_idelay_rst;
  logic             r_por;
  logic             r_sys_rdy;
  logic [7:0]       r_relock_count;
  logic             r_timeout_err;

  logic             w_lock_s;
  logic             w_rdy_s;
  logic             w_lock_loss;
  logic             w_timeout;
  logic             w_relock_inc;

  assign w_lock_s = r_lock_sync[1];
  assign w_rdy_s  = r_rdy_sync[1];

  // Two-flop synchronizers for the asynchronous LOCKED and RDY inputs.
  always_ff @(posedge epb_clk) begin
    // NOTE: non-blocking assignments let every flop sample pre-edge values,
    // independent of statement order.
    if (rst) begin
      r_lock_sync <= 2'b00;
      r_rdy_sync  <= 2'b00;
    end else begin
      r_lock_sync <= {r_lock_sync[0], mmcm_locked};
      r_rdy_sync  <= {r_rdy_sync[0], idelay_rdy};
    end
  end

`ifdef CLK_RST_SEQ_LOCK_FILTER_EN
  logic [1:0] r_flt_cnt;

  // Counts consecutive low lock cycles while RUN is held; clears otherwise.
  always_ff @(posedge epb_clk) begin
    if (rst) begin
      r_flt_cnt <= 2'd0;
    end else if (r_state != S_RUN || w_state_nxt != S_RUN || w_lock_s) begin
      r_flt_cnt <= 2'd0;
    end else if (r_flt_cnt != 2'd3) begin
      r_flt_cnt <= r_flt_cnt + 2'd1;
    end
  end

  // The fourth consecutive low cycle is the one that counts as a loss.
  assign w_lock_loss = (r_state == S_RUN) && !w_lock_s && (r_flt_cnt == 2'd3);
`else
  // Any low cycle of synchronized lock in RUN is a loss.
  assign w_lock_loss = (r_state == S_RUN) && !w_lock_s;
`endif

  // Next-state decode; lock problems take priority over every other event.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // infer a latch.
    w_state_nxt  = r_state;
    w_timeout    = 1'b0;
    w_relock_inc = 1'b0;
    case (r_state)
      S_MMCM_RST: begin
        if (r_cnt == MMCM_LAST) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = S_LOCK_STABLE;
        end else if (r_cnt == LOCK_TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_MMCM_RST;
        end
      end
      S_LOCK_STABLE: begin
        if (!w_lock_s)                 w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == STABLE_LAST) w_state_nxt = S_IDLY_RST;
      end
      S_IDLY_RST: begin
        if (!w_lock_s)               w_state_nxt = S_MMCM_RST;
        else if (r_cnt == IDLY_LAST) w_state_nxt = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (!w_lock_s) begin
          w_state_nxt = S_MMCM_RST;
        end else if (w_rdy_s) begin
          w_state_nxt = S_RUN;
        end else if (r_cnt == RDY_TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLY_RST;
        end
      end
      S_RUN: begin
        if (w_lock_loss) begin
          w_relock_inc = 1'b1;
          w_state_nxt  = S_MMCM_RST;
        end else if (force_rst) begin
          w_state_nxt = S_MMCM_RST;
        end else if (!w_rdy_s) begin
          w_state_nxt = S_IDLY_RST;
        end
      end
      default: w_state_nxt = S_MMCM_RST;
    endcase
  end

  // State register and shared interval counter (cleared on any state change).
  always_ff @(posedge epb_clk) begin
    if (rst) begin
      r_state <= S_MMCM_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (r_cnt != CNT_MAX)  r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Registered decode of next state, so outputs move with the state register.
  always_ff @(posedge epb_clk) begin
    if (rst) begin
      r_mmcm_rst     <= 1'b1;
      r_idelay_rst   <= 1'b0;
      r_por          <= 1'b1;
      r_sys_rdy      <= 1'b0;
      r_relock_count <= 8'd0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_mmcm_rst    <= (w_state_nxt == S_MMCM_RST);
      r_idelay_rst  <= (w_state_nxt == S_IDLY_RST);
      r_por         <= (w_state_nxt != S_RUN);
      r_sys_rdy     <= (w_state_nxt == S_RUN);
      r_timeout_err <= r_timeout_err | w_timeout;
      if (w_relock_inc && r_relock_count != 8'hFF) r_relock_count <= r_relock_count + 8'd1;
    end
  end

  assign mmcm_rst        = r_mmcm_rst;
  assign idelay_rst      = r_idelay_rst;
  assign op_power_on_rst = r_por;
  assign sys_rdy         = r_sys_rdy;
  assign relock_count    = r_relock_count;
  assign timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer with short intervals
// (MMCM 4, lock timeout 32, lock stable 8, IDELAY reset 3, RDY timeout 16).
// Inputs change 1 time unit after a rising edge; outputs are read there too.

module tb_clk_rst_sequencer;

  localparam int BOUND = 200;
`ifdef CLK_RST_SEQ_LOCK_FILTER_EN
  localparam int LOSS_LAT = 6;
`else
  localparam int LOSS_LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       mmcm_locked;
  logic       idelay_rdy;
  logic       force_rst;
  logic       mmcm_rst;
  logic       idelay_rst;
  logic       op_power_on_rst;
  logic       sys_rdy;
  logic [7:0] relock_count;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;
  int mmcm_seen;

  clk_rst_sequencer #(
    .MMCM_RST_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES (8),
    .IDELAY_RST_CYCLES  (3),
    .RDY_TIMEOUT_CYCLES (16)
  ) dut (
    .epb_clk        (clk),
    .rst            (rst),
    .mmcm_locked    (mmcm_locked),
    .idelay_rdy     (idelay_rdy),
    .force_rst      (force_rst),
    .mmcm_rst       (mmcm_rst),
    .idelay_rst     (idelay_rst),
    .op_power_on_rst(op_power_on_rst),
    .sys_rdy        (sys_rdy),
    .relock_count   (relock_count),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (mmcm_rst === 1'b1) mmcm_seen++;
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return mmcm_rst;
      1:       return idelay_rst;
      default: return sys_rdy;
    endcase
  endfunction

  // Steps until the selected output equals lvl; n is the number of edges taken.
  task automatic wait_level(input int sel, input logic lvl, input string name, output int n);
    n = 0;
    while (sig(sel) !== lvl && n < BOUND) begin
      step(1);
      n++;
    end
    if (n >= BOUND) begin
      checks++;
      failures++;
      $display("FAIL %s: timed out after %0d cycles waiting for level %b", name, n, lvl);
    end
  endtask

  task automatic start_seq(input logic lock, input logic rdy);
    rst = 1'b1; mmcm_locked = lock; idelay_rdy = rdy; force_rst = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic bring_up(output int n);
    start_seq(1'b1, 1'b1);
    wait_level(2, 1'b1, "bring_up_sys_rdy", n);
  endtask

  task automatic test_reset;
    rst = 1'b1; mmcm_locked = 1'b1; idelay_rdy = 1'b1; force_rst = 1'b0;
    step(3);
    checks++; if (mmcm_rst !== 1'b1) begin failures++; $display("FAIL reset_mmcm_rst: got %b want 1", mmcm_rst); end
    checks++; if (idelay_rst !== 1'b0) begin failures++; $display("FAIL reset_idelay_rst: got %b want 0", idelay_rst); end
    checks++; if (op_power_on_rst !== 1'b1) begin failures++; $display("FAIL reset_por: got %b want 1", op_power_on_rst); end
    checks++; if (sys_rdy !== 1'b0) begin failures++; $display("FAIL reset_sys_rdy: got %b want 0", sys_rdy); end
    checks++; if (relock_count !== 8'd0) begin failures++; $display("FAIL reset_relock: got %0d want 0", relock_count); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
  endtask

  task automatic test_nominal;
    int n;
    start_seq(1'b1, 1'b0);
    wait_level(0, 1'b0, "nom_mmcm_fall", n);
    checks++; if (n != 4) begin failures++; $display("FAIL nom_mmcm_width: got %0d want 4", n); end
    wait_level(1, 1'b1, "nom_idly_rise", n);
    checks++; if (n != 9) begin failures++; $display("FAIL nom_lock_qualify: got %0d want 9", n); end
    wait_level(1, 1'b0, "nom_idly_fall", n);
    checks++; if (n != 3) begin failures++; $display("FAIL nom_idly_width: got %0d want 3", n); end
    step(5);
    checks++; if (sys_rdy !== 1'b0) begin failures++; $display("FAIL nom_no_rdy_yet: got %b want 0", sys_rdy); end
    idelay_rdy = 1'b1;
    wait_level(2, 1'b1, "nom_sys_rdy", n);
    checks++; if (n != 3) begin failures++; $display("FAIL nom_rdy_latency: got %0d want 3", n); end
    checks++; if (op_power_on_rst !== 1'b0) begin failures++; $display("FAIL nom_por: got %b want 0", op_power_on_rst); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL nom_timeout: got %b want 0", timeout_err); end
    checks++; if (mmcm_rst !== 1'b0 || idelay_rst !== 1'b0) begin failures++; $display("FAIL nom_resets_low: got %b%b want 00", mmcm_rst, idelay_rst); end
  endtask

  task automatic test_bring_up;
    int n;
    bring_up(n);
    checks++; if (n != 17) begin failures++; $display("FAIL bring_up_latency: got %0d want 17", n); end
  endtask

  task automatic test_lock_timeout;
    int n;
    start_seq(1'b0, 1'b0);
    wait_level(0, 1'b0, "lto_fall1", n);
    checks++; if (n != 4) begin failures++; $display("FAIL lto_high1: got %0d want 4", n); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL lto_err_early: got %b want 0", timeout_err); end
    wait_level(0, 1'b1, "lto_rise1", n);
    checks++; if (n != 32) begin failures++; $display("FAIL lto_wait1: got %0d want 32", n); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL lto_err_set: got %b want 1", timeout_err); end
    wait_level(0, 1'b0, "lto_fall2", n);
    checks++; if (n != 4) begin failures++; $display("FAIL lto_high2: got %0d want 4", n); end
    wait_level(0, 1'b1, "lto_rise2", n);
    checks++; if (n != 32) begin failures++; $display("FAIL lto_wait2: got %0d want 32", n); end
    checks++; if (op_power_on_rst !== 1'b1) begin failures++; $display("FAIL lto_por: got %b want 1", op_power_on_rst); end
  endtask

  task automatic test_lock_chatter;
    int n;
    start_seq(1'b1, 1'b0);
    wait_level(0, 1'b0, "chat_mmcm_fall", n);
    step(5);
    mmcm_locked = 1'b0;
    step(1);
    mmcm_locked = 1'b1;
    wait_level(1, 1'b1, "chat_idly_rise", n);
    checks++; if (n != 11) begin failures++; $display("FAIL chat_requalify: got %0d want 11", n); end
    checks++; if (sys_rdy !== 1'b0) begin failures++; $display("FAIL chat_sys_rdy: got %b want 0", sys_rdy); end
    idelay_rdy = 1'b1;
    wait_level(2, 1'b1, "chat_sys_rdy_rise", n);
    checks++; if (n != 4) begin failures++; $display("FAIL chat_run_latency: got %0d want 4", n); end
  endtask

  task automatic test_lock_loss_run;
    int n;
    bring_up(n);
    mmcm_locked = 1'b0;
    step(1);
    mmcm_locked = 1'b1;
    step(3);
`ifdef CLK_RST_SEQ_LOCK_FILTER_EN
    checks++; if (sys_rdy !== 1'b1 || mmcm_rst !== 1'b0) begin failures++; $display("FAIL loss1_filtered: got sys_rdy=%b mmcm_rst=%b want 1 0", sys_rdy, mmcm_rst); end
    checks++; if (relock_count !== 8'd0) begin failures++; $display("FAIL loss1_count: got %0d want 0", relock_count); end
    mmcm_locked = 1'b0;
    step(3);
    mmcm_locked = 1'b1;
    step(5);
    checks++; if (sys_rdy !== 1'b1 || relock_count !== 8'd0) begin failures++; $display("FAIL loss3_filtered: got sys_rdy=%b count=%0d want 1 0", sys_rdy, relock_count); end
`else
    checks++; if (op_power_on_rst !== 1'b1 || mmcm_rst !== 1'b1) begin failures++; $display("FAIL loss1_react: got por=%b mmcm_rst=%b want 1 1", op_power_on_rst, mmcm_rst); end
    checks++; if (relock_count !== 8'd1) begin failures++; $display("FAIL loss1_count: got %0d want 1", relock_count); end
    wait_level(2, 1'b1, "loss1_recover", n);
    checks++; if (relock_count !== 8'd1) begin failures++; $display("FAIL loss1_count_after: got %0d want 1", relock_count); end
`endif
    bring_up(n);
    mmcm_locked = 1'b0;
    step(4);
    mmcm_locked = 1'b1;
    wait_level(2, 1'b1, "loss4_recover", n);
    checks++; if (relock_count !== 8'd1) begin failures++; $display("FAIL loss4_count: got %0d want 1", relock_count); end
  endtask

  task automatic test_simultaneous;
    int n;
    bring_up(n);
    mmcm_locked = 1'b0;
    for (int i = 1; i <= LOSS_LAT; i++) begin
      force_rst = (i == LOSS_LAT);
      step(1);
      if (i == 4) mmcm_locked = 1'b1;
    end
    force_rst   = 1'b0;
    mmcm_locked = 1'b1;
    checks++; if (mmcm_rst !== 1'b1 || relock_count !== 8'd1) begin failures++; $display("FAIL simul_entry: got mmcm_rst=%b count=%0d want 1 1", mmcm_rst, relock_count); end
    wait_level(0, 1'b0, "simul_mmcm_fall", n);
    checks++; if (n != 4) begin failures++; $display("FAIL simul_single_pulse: got %0d want 4", n); end
    wait_level(2, 1'b1, "simul_recover", n);
    checks++; if (relock_count !== 8'd1) begin failures++; $display("FAIL simul_count: got %0d want 1", relock_count); end
  endtask

  task automatic test_force;
    int n;
    bring_up(n);
    force_rst = 1'b1;
    step(1);
    force_rst = 1'b0;
    checks++; if (mmcm_rst !== 1'b1 || sys_rdy !== 1'b0) begin failures++; $display("FAIL force_entry: got mmcm_rst=%b sys_rdy=%b want 1 0", mmcm_rst, sys_rdy); end
    force_rst = 1'b1;
    step(2);
    force_rst = 1'b0;
    wait_level(0, 1'b0, "force_mmcm_fall", n);
    checks++; if (n != 2) begin failures++; $display("FAIL force_ignored_outside_run: got %0d want 2", n); end
    wait_level(2, 1'b1, "force_recover", n);
    checks++; if (relock_count !== 8'd0) begin failures++; $display("FAIL force_count: got %0d want 0", relock_count); end
  endtask

  task automatic test_rdy_race;
    int n;
    start_seq(1'b1, 1'b0);
    wait_level(1, 1'b1, "race_idly_rise", n);
    wait_level(1, 1'b0, "race_idly_fall", n);
    step(13);
    idelay_rdy = 1'b1;
    step(3);
    checks++; if (sys_rdy !== 1'b1 || idelay_rst !== 1'b0) begin failures++; $display("FAIL race_run: got sys_rdy=%b idelay_rst=%b want 1 0", sys_rdy, idelay_rst); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL race_timeout: got %b want 0", timeout_err); end
  endtask

  task automatic test_rdy_loss;
    int n;
    bring_up(n);
    mmcm_seen = 0;
    idelay_rdy = 1'b0;
    wait_level(1, 1'b1, "rdyl_idly_rise", n);
    checks++; if (n != 3) begin failures++; $display("FAIL rdyl_latency: got %0d want 3", n); end
    checks++; if (sys_rdy !== 1'b0 || op_power_on_rst !== 1'b1) begin failures++; $display("FAIL rdyl_leave_run: got sys_rdy=%b por=%b want 0 1", sys_rdy, op_power_on_rst); end
    wait_level(1, 1'b0, "rdyl_idly_fall", n);
    checks++; if (n != 3) begin failures++; $display("FAIL rdyl_idly_width: got %0d want 3", n); end
    wait_level(1, 1'b1, "rdyl_timeout_rise", n);
    checks++; if (n != 16) begin failures++; $display("FAIL rdyl_rdy_timeout: got %0d want 16", n); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL rdyl_err: got %b want 1", timeout_err); end
    wait_level(1, 1'b0, "rdyl_idly_fall2", n);
    checks++; if (n != 3) begin failures++; $display("FAIL rdyl_idly_width2: got %0d want 3", n); end
    idelay_rdy = 1'b1;
    wait_level(2, 1'b1, "rdyl_recover", n);
    checks++; if (n != 3) begin failures++; $display("FAIL rdyl_return: got %0d want 3", n); end
    checks++; if (mmcm_seen != 0) begin failures++; $display("FAIL rdyl_mmcm_quiet: got %0d high cycles want 0", mmcm_seen); end
  endtask

  task automatic test_saturate;
    int n;
    bring_up(n);
    for (int k = 1; k <= 300; k++) begin
      mmcm_locked = 1'b0;
      step(4);
      mmcm_locked = 1'b1;
      wait_level(2, 1'b1, "sat_recover", n);
      if (k == 254) begin
        checks++; if (relock_count !== 8'd254) begin failures++; $display("FAIL sat_254: got %0d want 254", relock_count); end
      end
    end
    checks++; if (relock_count !== 8'd255) begin failures++; $display("FAIL sat_255: got %0d want 255", relock_count); end
  endtask

  task automatic test_mid_reset;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if (relock_count !== 8'd0) begin failures++; $display("FAIL midrst_count: got %0d want 0", relock_count); end
    checks++; if (mmcm_rst !== 1'b1 || sys_rdy !== 1'b0 || op_power_on_rst !== 1'b1) begin failures++; $display("FAIL midrst_outputs: got mmcm=%b sys_rdy=%b por=%b want 1 0 1", mmcm_rst, sys_rdy, op_power_on_rst); end
  endtask

  initial begin
    rst = 1'b1; mmcm_locked = 1'b0; idelay_rdy = 1'b0; force_rst = 1'b0;
    mmcm_seen = 0;
    test_reset();
    test_nominal();
    test_bring_up();
    test_lock_timeout();
    test_lock_chatter();
    test_lock_loss_run();
    test_simultaneous();
    test_force();
    test_rdy_race();
    test_rdy_loss();
    test_saturate();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_rst_sequencer.md
Name: clk_rst_sequencer

Overview:
- Free-running power-up and recovery sequencer for the board clock infrastructure, clocked from the EPB clock (not from any MMCM output).
- Sequence: drives the system MMCM reset, qualifies LOCKED, then pulses the IDELAYCTRL reset and waits for RDY.
- Only then releases the design-wide power-on reset.
- On lock loss, IDELAYCTRL ready loss or a software request, it re-runs the minimal part of the sequence and records the event in status registers.

Parameters:
- MMCM_RST_CYCLES, 16, cycles mmcm_rst is held high per reset attempt (>=1)
- LOCK_TIMEOUT_CYCLES, 65536, cycles to wait for lock before retrying the MMCM reset
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before proceeding
- IDELAY_RST_CYCLES, 8, cycles idelay_rst is held high (>=1)
- RDY_TIMEOUT_CYCLES, 4096, cycles to wait for idelay_rdy before re-pulsing idelay_rst
- Internal counter width: clog2 of the largest parameter. One shared counter.

Ports:
- epb_clk  in  1  sequencer clock, free-running
- rst  in  1  synchronous, active-high reset
- mmcm_locked  in  1  MMCM LOCKED, asynchronous; 2-FF synchronized internally
- idelay_rdy  in  1  IDELAYCTRL RDY, asynchronous; 2-FF synchronized internally
- force_rst  in  1  software re-sequence request, synchronous to epb_clk, level or pulse
- mmcm_rst  out  1  MMCM RST
- idelay_rst  out  1  IDELAYCTRL RST
- op_power_on_rst  out  1  design-wide reset, high until sequence complete
- sys_rdy  out  1  high only in RUN; equals ~op_power_on_rst
- relock_count  out  8  saturating count of lock losses seen in RUN
- timeout_err  out  1  sticky; set on any lock or rdy timeout

Behaviour:
- Clock and reset: one clock, epb_clk. Reset rst is synchronous and active-high.
- Reset values: state MMCM_RST, counter 0, mmcm_rst=1, idelay_rst=0, op_power_on_rst=1, sys_rdy=0, relock_count=0, timeout_err=0. Synchronizer flops reset to 0.
- Output timing: all outputs are registered decodes of next-state and change on the same edge as the state register. No combinational path from inputs to outputs.
- Counter: clears on every state change. Otherwise increments, saturating.
- lock_s and rdy_s denote the synchronized inputs (2-cycle latency).
- States and transitions (priority top to bottom within each state):
  - MMCM_RST: mmcm_rst=1. Counter == MMCM_RST_CYCLES-1 -> WAIT_LOCK.
  - WAIT_LOCK: lock_s=1 -> LOCK_STABLE. Counter == LOCK_TIMEOUT_CYCLES-1 -> set timeout_err, go to MMCM_RST.
  - LOCK_STABLE: lock_s=0 -> WAIT_LOCK. Counter == LOCK_STABLE_CYCLES-1 -> IDLY_RST.
  - IDLY_RST: idelay_rst=1. lock_s=0 -> MMCM_RST. Counter == IDELAY_RST_CYCLES-1 -> WAIT_RDY.
  - WAIT_RDY: lock_s=0 -> MMCM_RST. rdy_s=1 -> RUN. Counter == RDY_TIMEOUT_CYCLES-1 -> set timeout_err, go to IDLY_RST.
  - RUN: op_power_on_rst=0, sys_rdy=1.
    - lock loss -> relock_count+1 (saturate at 255), go to MMCM_RST.
    - else force_rst=1 -> MMCM_RST, no count increment.
    - else rdy_s=0 -> IDLY_RST.
- force_rst outside RUN: ignored; the sequence is already running.
- Simultaneous events: lock loss beats force_rst, rdy loss and timeouts. rdy_s=1 beats an RDY timeout in the same cycle.
- op_power_on_rst is 1 in every state except RUN. It reasserts on the same edge RUN is left.
- relock_count and timeout_err clear only on rst.
- rst asserted mid-sequence aborts immediately to the reset values on the next edge.

Optional Feature:
- Macro: CLK_RST_SEQ_LOCK_FILTER_EN
- Defined: in RUN, "lock loss" means lock_s low for 4 consecutive cycles. A shorter dropout is ignored and does not count. The filter counter clears on lock_s=1 and on leaving RUN.
- Undefined: in RUN, "lock loss" means lock_s low for a single cycle.
- The filter applies to RUN only. Other states always react to single-cycle lock_s=0.

Test Plan (bench params MMCM_RST=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, IDELAY_RST=3, RDY_TIMEOUT=16):
- Nominal power-up: rst released, mmcm_locked=1 from start, idelay_rdy rises 5 cycles into WAIT_RDY -> mmcm_rst high exactly 4 cycles; idelay_rst high exactly 3 cycles; sys_rdy rises 2 cycles after idelay_rdy (sync) +1 edge; timeout_err=0.
- Lock timeout: mmcm_locked held 0 -> mmcm_rst re-pulses every 4+32 cycles; timeout_err=1 after first 32-cycle wait; op_power_on_rst stays 1.
- Lock chatter in LOCK_STABLE: lock drops after 5 stable cycles -> back to WAIT_LOCK; sys_rdy delayed until 8 uninterrupted cycles.
- Lock loss in RUN: drop mmcm_locked for 1 cycle -> unfiltered: op_power_on_rst=1, mmcm_rst re-pulses, relock_count=1. With CLK_RST_SEQ_LOCK_FILTER_EN: no effect. A 4-cycle drop gives relock_count=1. 300 losses give relock_count=255.
- Simultaneous force_rst and lock loss in RUN -> relock_count increments once, single MMCM_RST entry. force_rst alone -> relock_count unchanged.
- idelay_rdy drops in RUN -> idelay_rst pulses 3 cycles, mmcm_rst stays 0, sys_rdy returns after rdy_s=1.
